// File: rtl/debug_uart_tx_framer.sv
// debug_uart_tx_framer
// Transmit side of the debug-unit host link. It frames debug responses as
// byte packets and sends every byte as 8N1 UART (start, 8 data bits LSB
// first, stop) on uart_tx.
//   OK packet     : [OP_OK]
//   SIGNAL packet : [OP_SIGNAL, pc[7:0], pc[15:8], pc[23:16], pc[31:24],
//                    signals[7:0], ..., signals[8*SIG_BYTES-1 -: 8]]
// Optional feature macro: DEBUG_TX_CHECKSUM_EN. When it is defined, every
// packet gets one trailing byte equal to the XOR of all earlier bytes of
// that packet, including the opcode.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   ok_req    in   request an OP_OK packet (sampled only while req_ready=1)
//   sig_req   in   request an OP_SIGNAL packet (sampled only while req_ready=1)
//   pc        in   program counter, captured when sig_req is accepted
//   signals   in   signal snapshot, captured when sig_req is accepted
//   req_ready out  high in IDLE with nothing pending
//   busy      out  high from acceptance until the last stop bit ends
//   pkt_done  out  one-cycle pulse after a packet's final stop bit
//   uart_tx   out  serial line, idles high
//
// CLKS_PER_BIT must be at least 2: the final stop-bit cycle is spent in NEXT.

module debug_uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SIG_BYTES    = 4,
    parameter logic [7:0]  OP_SIGNAL    = 8'h01,
    parameter logic [7:0]  OP_OK        = 8'h02
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ok_req,
    input  logic                   sig_req,
    input  logic [31:0]            pc,
    input  logic [8*SIG_BYTES-1:0] signals,
    output logic                   req_ready,
    output logic                   busy,
    output logic                   pkt_done,
    output logic                   uart_tx
);

    localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W     = $clog2(6 + SIG_BYTES);
    localparam int unsigned PAY_BYTES = 5 + SIG_BYTES;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int unsigned CSUM_BYTES = 1;
`else
    localparam int unsigned CSUM_BYTES = 0;
`endif
    localparam int unsigned OK_LAST  = CSUM_BYTES;
    localparam int unsigned SIG_LAST = PAY_BYTES - 1 + CSUM_BYTES;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_STOP_END = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [IDX_W-1:0]       byte_idx;
    logic [7:0]             shreg;
    logic                   pkt_sig;
    logic                   sig_pending;
    logic [31:0]            pc_q;
    logic [8*SIG_BYTES-1:0] sig_q;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0]             csum_q;
`endif

    logic [8*PAY_BYTES-1:0] payload_c;
    logic [IDX_W-1:0]       next_idx_c;
    logic [IDX_W-1:0]       last_idx_c;
    logic                   last_c;
    logic [7:0]             next_byte_c;

    // Signal packet payload laid out in transmit order, byte 0 = opcode.
    assign payload_c  = {sig_q, pc_q, OP_SIGNAL};
    assign next_idx_c = byte_idx + IDX_W'(1);
    assign last_idx_c = pkt_sig ? IDX_W'(SIG_LAST) : IDX_W'(OK_LAST);
    assign last_c     = (byte_idx == last_idx_c);

    // Byte to load when advancing to the next byte of the current packet.
    always_comb begin
        next_byte_c = 8'h00;
        for (int i = 1; i < int'(PAY_BYTES); i++) begin
            if (next_idx_c == IDX_W'(i)) begin
                next_byte_c = payload_c[8*i +: 8];
            end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        if (next_idx_c == last_idx_c) begin
            next_byte_c = csum_q;
        end
`endif
    end

    // Framer FSM: packet sequencing, bit timing and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            pkt_sig     <= 1'b0;
            sig_pending <= 1'b0;
            pc_q        <= '0;
            sig_q       <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            pkt_done    <= 1'b0;
            uart_tx     <= 1'b1;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ok_req || sig_req) begin
                        // ok_req wins; a simultaneous sig_req is parked as pending.
                        state       <= START;
                        cnt         <= '0;
                        bit_idx     <= '0;
                        byte_idx    <= '0;
                        pkt_sig     <= ~ok_req;
                        sig_pending <= ok_req & sig_req;
                        shreg       <= ok_req ? OP_OK : OP_SIGNAL;
`ifdef DEBUG_TX_CHECKSUM_EN
                        csum_q      <= ok_req ? OP_OK : OP_SIGNAL;
`endif
                        if (sig_req) begin
                            pc_q  <= pc;
                            sig_q <= signals;
                        end
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        uart_tx     <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Stop bit minus its last cycle; NEXT supplies that final cycle.
                STOP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_STOP_END) begin
                        state <= NEXT;
                    end
                end

                // Last stop-bit cycle: pick the next byte or finish the packet
                // so the following start bit has no idle gap.
                NEXT: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!last_c) begin
                        state    <= START;
                        byte_idx <= next_idx_c;
                        shreg    <= next_byte_c;
`ifdef DEBUG_TX_CHECKSUM_EN
                        csum_q   <= csum_q ^ next_byte_c;
`endif
                        uart_tx  <= 1'b0;
                    end else begin
                        pkt_done <= 1'b1;
                        if (sig_pending) begin
                            sig_pending <= 1'b0;
                            state       <= START;
                            byte_idx    <= '0;
                            pkt_sig     <= 1'b1;
                            shreg       <= OP_SIGNAL;
`ifdef DEBUG_TX_CHECKSUM_EN
                            csum_q      <= OP_SIGNAL;
`endif
                            uart_tx     <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            uart_tx   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    uart_tx   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/debug_uart_tx_framer.md
Name: debug_uart_tx_framer

Overview:
Transmit side of the debug-unit host link. Frames debug responses to the client PC as packets: OP_OK for a received ping, or OP_SIGNAL followed by the PC and the signal snapshot. It serializes each packet byte as 8N1 UART on uart_tx. It sits beside the existing debug UART receiver and opcode decoder, and drives the board's uart_tx pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (868 at 100 MHz gives 115200 baud)
SIG_BYTES, 4, number of signal-snapshot bytes sent after the PC in an OP_SIGNAL packet
OP_SIGNAL, 8'h01, opcode byte leading a signal packet
OP_OK, 8'h02, opcode byte of a ping reply

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
ok_req  input  1  request an OP_OK packet; sampled only while req_ready=1
sig_req  input  1  request an OP_SIGNAL packet; sampled only while req_ready=1
pc  input  32  program counter, captured on sig_req acceptance
signals  input  8*SIG_BYTES  signal snapshot, captured on sig_req acceptance
req_ready  output  1  high when in IDLE with nothing pending
busy  output  1  high from acceptance until the last stop bit ends (drives uart_in_progress)
pkt_done  output  1  one-cycle pulse after a packet's final stop bit
uart_tx  output  1  serial line, idles high, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: uart_tx=1, req_ready=1, busy=0, pkt_done=0. All counters, the pending flag and the captured data are cleared.
- Reset mid-frame: uart_tx=1 on the cycle after rst_n is sampled low. The partial packet is discarded and is not resumed.
- FSM states: IDLE, START, DATA, STOP, NEXT.
- IDLE, acceptance:
  - ok_req, or sig_req, high at a clk edge is accepted.
  - ok_req has priority over sig_req.
  - If both are high in the same cycle, both are accepted: the OK packet is sent first, then the signal packet. pc and signals are captured in the same cycle and sig_pending is set.
- START: uart_tx=0 for CLKS_PER_BIT cycles. The first start-bit cycle is the cycle after acceptance (latency 1).
- DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles.
- NEXT:
  - If bytes remain, go to START on the following cycle with no idle gap, so each byte takes exactly 10*CLKS_PER_BIT cycles.
  - Otherwise pulse pkt_done. Then, if sig_pending is set, clear it and begin the signal packet next cycle. Otherwise return to IDLE.
- Packet byte order:
  - OK: [OP_OK], 1 byte.
  - SIGNAL: [OP_SIGNAL, pc[7:0], pc[15:8], pc[23:16], pc[31:24], signals[7:0], ..., signals[8*SIG_BYTES-1:8*SIG_BYTES-8]], 5+SIG_BYTES bytes.
- Requests while req_ready=0 are ignored, not queued.
- The captured pc and signals are immune to input changes after acceptance.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps exactly; no drift across bytes.
- Byte index width: clog2(6+SIG_BYTES).

Optional Feature:
DEBUG_TX_CHECKSUM_EN
- Defined: every packet gets one trailing byte equal to the XOR of all preceding bytes in that packet, including the opcode. OK becomes [02,02]; SIGNAL becomes 6+SIG_BYTES bytes.
- Undefined: no checksum byte; the lengths above apply and no checksum logic is synthesized.

Test Plan:
- Reset then idle 20000 cycles -> uart_tx=1 throughout, req_ready=1, busy=0, pkt_done never pulses.
- ok_req pulse one cycle -> uart_tx sequence 0,0,1,0,0,0,0,0,0,1, each bit 868 cycles. busy high 8680 cycles. pkt_done pulses at cycle 8681 after acceptance. req_ready returns to 1.
- sig_req with pc=32'h0000_0040, signals=32'hA5C3_0F01 -> decoded bytes 01,40,00,00,00,01,0F,C3,A5 back-to-back, total 78120 cycles. Changing pc after acceptance does not alter the bytes.
- ok_req and sig_req together (pc=4, signals=0) -> bytes 02, then 01,04,00,00,00,00,00,00,00, with no idle gap. pkt_done pulses twice, at 8681 and 86801 cycles.
- ok_req asserted during a signal packet, and rst_n low for one cycle at the mid-point of byte 3 -> the ok_req produces no packet. uart_tx=1 the cycle after reset, outputs return to reset values, and a subsequent ok_req sends a clean 02.
- With DEBUG_TX_CHECKSUM_EN, ok_req -> bytes 02,02. sig_req with pc=1, signals=0 -> the 10th byte equals 01^01=00.
